// File: rtl/axi_lite_multi_counter.sv
`timescale 1ns / 1ps
// ---------------------------------------------------------------------------
// axi_lite_multi_counter
// AXI4-Lite slave with NUM_CH independent counters. Each channel has a
// 16-byte register window: CTRL (en/down/auto_reload/irq_en), LOAD,
// COUNT (read-only) and STATUS (tc, write-1-to-clear).
//
// Ports:
//   s00_axi_aclk / s00_axi_aresetn : clock, asynchronous active-low reset
//   s00_axi_aw* / w* / b*           : AXI4-Lite write address/data/response
//   s00_axi_ar* / r*                : AXI4-Lite read address/data
//   cnt_tick[NUM_CH]                : per-channel count enable strobe
//   tc_pulse[NUM_CH]                : one-cycle terminal-count pulse
//   irq                             : OR of (tc & irq_en) over channels
// ---------------------------------------------------------------------------
module axi_lite_multi_counter #(
  parameter int NUM_CH             = 4,
  parameter int CNT_WIDTH          = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 7
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  input  logic [NUM_CH-1:0]               cnt_tick,
  output logic [NUM_CH-1:0]               tc_pulse,
  output logic                            irq
);

  localparam int CH_W = C_S_AXI_ADDR_WIDTH - 4;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_LOAD   = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1'b1);

  // Merge new write data into an old word byte by byte under the strobes.
  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_v[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_v[8*b +: 8];
      end
    end
    return res;
  endfunction

  // Zero-extend a counter-width value to the bus width.
  function automatic logic [31:0] zext(input logic [CNT_WIDTH-1:0] v);
    logic [31:0] res;
    res = 32'd0;
    res[CNT_WIDTH-1:0] = v;
    return res;
  endfunction

  // AXI handshake state
  logic        wr_ready_r;
  logic        bvalid_r;
  logic        arready_r;
  logic        rvalid_r;
  logic [31:0] rdata_r;
  logic        irq_r;

  // Channel state and next-state
  logic [3:0]           ctrl_r  [NUM_CH];
  logic [3:0]           ctrl_n  [NUM_CH];
  logic [CNT_WIDTH-1:0] load_r  [NUM_CH];
  logic [CNT_WIDTH-1:0] load_n  [NUM_CH];
  logic [CNT_WIDTH-1:0] count_r [NUM_CH];
  logic [CNT_WIDTH-1:0] count_n [NUM_CH];
  logic [NUM_CH-1:0]    tc_r;
  logic [NUM_CH-1:0]    tc_n;
  logic [NUM_CH-1:0]    pulse_r;
  logic [NUM_CH-1:0]    pulse_n;

  // Decode
  logic              wr_fire_s;
  logic              rd_fire_s;
  logic [CH_W-1:0]   wr_ch_s;
  logic [CH_W-1:0]   rd_ch_s;
  logic [1:0]        wr_reg_s;
  logic [1:0]        rd_reg_s;
  logic [31:0]       ctrl_wr_s;
  logic [31:0]       load_wr_s;
  logic [31:0]       rd_data_s;
  logic [NUM_CH-1:0] hit_s;
  logic [NUM_CH-1:0] tick_s;
  logic [NUM_CH-1:0] term_s;
  logic [NUM_CH-1:0] irq_en_s;
  logic              unused_s;

  // wready is asserted together with awready, so a single register drives both.
  assign wr_fire_s = wr_ready_r & s00_axi_awvalid & s00_axi_wvalid;
  assign rd_fire_s = arready_r & s00_axi_arvalid;
  assign wr_ch_s   = s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:4];
  assign wr_reg_s  = s00_axi_awaddr[3:2];
  assign rd_ch_s   = s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:4];
  assign rd_reg_s  = s00_axi_araddr[3:2];
  assign unused_s  = ^{s00_axi_awprot, s00_axi_arprot,
                       s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  assign s00_axi_awready = wr_ready_r;
  assign s00_axi_wready  = wr_ready_r;
  assign s00_axi_bvalid  = bvalid_r;
  assign s00_axi_bresp   = 2'b00;
  assign s00_axi_arready = arready_r;
  assign s00_axi_rvalid  = rvalid_r;
  assign s00_axi_rdata   = rdata_r;
  assign s00_axi_rresp   = 2'b00;
  assign tc_pulse        = pulse_r;
  assign irq             = irq_r;

  // Per-channel write hit, qualified tick and terminal condition.
  always_comb begin
    hit_s    = {NUM_CH{1'b0}};
    tick_s   = {NUM_CH{1'b0}};
    term_s   = {NUM_CH{1'b0}};
    irq_en_s = {NUM_CH{1'b0}};
    for (int c = 0; c < NUM_CH; c++) begin
      // Channel indices at or above NUM_CH never match, so such writes drop.
      hit_s[c]    = wr_fire_s & (wr_ch_s == CH_W'(c));
      // A CTRL/LOAD write owns COUNT this cycle, so the tick is discarded.
      tick_s[c]   = ctrl_r[c][0] & cnt_tick[c] &
                    ~(hit_s[c] & ((wr_reg_s == REG_CTRL) || (wr_reg_s == REG_LOAD)));
      term_s[c]   = ctrl_r[c][1] ? (count_r[c] == CNT_ZERO) : (count_r[c] == load_r[c]);
      irq_en_s[c] = ctrl_r[c][3];
    end
  end

  // Channel next-state: register writes first, then tick so a terminal set beats a clear.
  always_comb begin
    ctrl_wr_s = 32'd0;
    load_wr_s = 32'd0;
    tc_n      = tc_r;
    pulse_n   = {NUM_CH{1'b0}};
    for (int c = 0; c < NUM_CH; c++) begin
      ctrl_n[c]  = ctrl_r[c];
      load_n[c]  = load_r[c];
      count_n[c] = count_r[c];
      ctrl_wr_s  = apply_strb({28'd0, ctrl_r[c]}, s00_axi_wdata, s00_axi_wstrb);
      load_wr_s  = apply_strb(zext(load_r[c]), s00_axi_wdata, s00_axi_wstrb);

      if (hit_s[c]) begin
        case (wr_reg_s)
          REG_CTRL: begin
            ctrl_n[c] = ctrl_wr_s[3:0];
            // Flipping direction restarts from the new direction's start value.
            if (ctrl_wr_s[1] != ctrl_r[c][1]) begin
              count_n[c] = ctrl_wr_s[1] ? load_r[c] : CNT_ZERO;
            end else begin
              count_n[c] = count_r[c];
            end
          end
          REG_LOAD: begin
            load_n[c]  = load_wr_s[CNT_WIDTH-1:0];
            count_n[c] = ctrl_r[c][1] ? load_wr_s[CNT_WIDTH-1:0] : CNT_ZERO;
          end
          REG_STATUS: begin
            if (s00_axi_wstrb[0] && s00_axi_wdata[0]) begin
              tc_n[c] = 1'b0;
            end else begin
              tc_n[c] = tc_r[c];
            end
          end
          REG_COUNT: begin
            count_n[c] = count_r[c];
          end
          default: begin
            count_n[c] = count_r[c];
          end
        endcase
      end else begin
        ctrl_n[c] = ctrl_r[c];
      end

      if (tick_s[c]) begin
        if (term_s[c]) begin
          pulse_n[c] = 1'b1;
          tc_n[c]    = 1'b1;
          if (ctrl_r[c][2]) begin
            count_n[c] = ctrl_r[c][1] ? load_r[c] : CNT_ZERO;
          end else begin
            ctrl_n[c][0] = 1'b0;
            count_n[c]   = count_r[c];
          end
        end else begin
          count_n[c] = ctrl_r[c][1] ? (count_r[c] - CNT_ONE) : (count_r[c] + CNT_ONE);
        end
      end else begin
        pulse_n[c] = 1'b0;
      end
    end
  end

  // Read data mux; unmapped channels read as zero.
  always_comb begin
    rd_data_s = 32'd0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_ch_s == CH_W'(c)) begin
        case (rd_reg_s)
          REG_CTRL:   rd_data_s = {28'd0, ctrl_r[c]};
          REG_LOAD:   rd_data_s = zext(load_r[c]);
          REG_COUNT:  rd_data_s = zext(count_r[c]);
          REG_STATUS: rd_data_s = {31'd0, tc_r[c]};
          default:    rd_data_s = 32'd0;
        endcase
      end else begin
        rd_data_s = rd_data_s;
      end
    end
  end

  // AXI write/read handshake registers.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      wr_ready_r <= 1'b0;
      bvalid_r   <= 1'b0;
      arready_r  <= 1'b0;
      rvalid_r   <= 1'b0;
      rdata_r    <= 32'd0;
    end else begin
      wr_ready_r <= ~wr_ready_r & s00_axi_awvalid & s00_axi_wvalid & ~bvalid_r;
      if (wr_fire_s) begin
        bvalid_r <= 1'b1;
      end else if (s00_axi_bready) begin
        bvalid_r <= 1'b0;
      end else begin
        bvalid_r <= bvalid_r;
      end

      arready_r <= ~arready_r & s00_axi_arvalid & ~rvalid_r;
      if (rd_fire_s) begin
        rvalid_r <= 1'b1;
        rdata_r  <= rd_data_s;
      end else if (s00_axi_rready) begin
        rvalid_r <= 1'b0;
      end else begin
        rvalid_r <= rvalid_r;
      end
    end
  end

  // Counter channel registers and interrupt.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      for (int c = 0; c < NUM_CH; c++) begin
        ctrl_r[c]  <= 4'd0;
        load_r[c]  <= CNT_ZERO;
        count_r[c] <= CNT_ZERO;
      end
      tc_r    <= {NUM_CH{1'b0}};
      pulse_r <= {NUM_CH{1'b0}};
      irq_r   <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        ctrl_r[c]  <= ctrl_n[c];
        load_r[c]  <= load_n[c];
        count_r[c] <= count_n[c];
      end
      tc_r    <= tc_n;
      pulse_r <= pulse_n;
      irq_r   <= |(tc_r & irq_en_s);
    end
  end

endmodule

// File: tb/tb_axi_lite_multi_counter.sv
`timescale 1ns / 1ps
// Directed bench for axi_lite_multi_counter with NUM_CH=3, CNT_WIDTH=8.
module tb_axi_lite_multi_counter;

  localparam int NCH = 3;
  localparam int CW  = 8;
  localparam int AW  = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] awaddr;
  logic [2:0]    awprot;
  logic          awvalid;
  logic          awready;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic          wvalid;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;
  logic [AW-1:0] araddr;
  logic [2:0]    arprot;
  logic          arvalid;
  logic          arready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;
  logic [NCH-1:0] cnt_tick;
  logic [NCH-1:0] tc_pulse;
  logic           irq;

  int n_tests = 0;
  int n_fail  = 0;

  axi_lite_multi_counter #(
    .NUM_CH(NCH), .CNT_WIDTH(CW), .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(AW)
  ) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid),
    .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid),
    .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
    .s00_axi_rready(rready),
    .cnt_tick(cnt_tick), .tc_pulse(tc_pulse), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_edge();
    @(posedge clk);
    #1;
  endtask

  // Full write; hs_tick is driven on cnt_tick during the handshake cycle only.
  // Returns 1 ns after the handshake edge with bvalid up and bready high.
  task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [NCH-1:0] hs_tick);
    int n;
    wait_edge();
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    while (awready !== 1'b1 && n < 20) begin
      wait_edge();
      n++;
    end
    check("wr_awready", 32'(awready), 32'd1);
    check("wr_wready", 32'(wready), 32'd1);
    cnt_tick = hs_tick;
    wait_edge();
    cnt_tick = '0; awvalid = 1'b0; wvalid = 1'b0;
    check("wr_bvalid", 32'(bvalid), 32'd1);
    check("wr_bresp", 32'(bresp), 32'd0);
  endtask

  task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d);
    int n;
    wait_edge();
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (arready !== 1'b1 && n < 20) begin
      wait_edge();
      n++;
    end
    check("rd_arready", 32'(arready), 32'd1);
    wait_edge();
    arvalid = 1'b0;
    check("rd_rvalid", 32'(rvalid), 32'd1);
    check("rd_rresp", 32'(rresp), 32'd0);
    d = rdata;
  endtask

  task automatic rd_check(input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    axi_read(a, d);
    check(tag, d, exp);
  endtask

  // One tick cycle on the given mask; checks the tc_pulse vector that follows.
  task automatic pulse_tick(input logic [NCH-1:0] mask, input logic [NCH-1:0] exp_pulse);
    wait_edge();
    cnt_tick = mask;
    wait_edge();
    cnt_tick = '0;
    check("tc_pulse", 32'(tc_pulse), 32'(exp_pulse));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [NCH-1:0] exp_p [6];
    logic [7:0]     exp_c [6];
    logic [NCH-1:0] held_p [4];
    int n;

    rst_n = 1'b0;
    awaddr = '0; awprot = 3'd0; awvalid = 1'b0; wdata = 32'd0; wstrb = 4'd0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arprot = 3'd0; arvalid = 1'b0; rready = 1'b0; cnt_tick = '0;
    repeat (3) wait_edge();
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4 * NCH; i++) rd_check("rst_regs", 7'(i * 4), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_tc_pulse", 32'(tc_pulse), 32'd0);

    // Ch0: up, auto-reload, LOAD=3
    axi_write(7'h04, 32'd3, 4'hF, 3'b000);
    axi_write(7'h00, 32'h5, 4'hF, 3'b000);
    rd_check("ch0_ctrl", 7'h00, 32'h5);
    rd_check("ch0_count0", 7'h08, 32'd0);
    exp_p = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000};
    exp_c = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2};
    for (int i = 0; i < 6; i++) begin
      pulse_tick(3'b001, exp_p[i]);
      rd_check("ch0_count_seq", 7'h08, 32'(exp_c[i]));
    end
    held_p = '{3'b000, 3'b001, 3'b000, 3'b000};
    wait_edge();
    cnt_tick = 3'b001;
    for (int i = 0; i < 4; i++) begin
      wait_edge();
      check("ch0_held_pulse", 32'(tc_pulse), 32'(held_p[i]));
    end
    cnt_tick = '0;
    rd_check("ch0_count_held", 7'h08, 32'd2);
    rd_check("ch0_status", 7'h0C, 32'd1);
    check("ch0_no_irq", 32'(irq), 32'd0);

    // Ch1: down, one-shot, irq_en, LOAD=2
    axi_write(7'h14, 32'd2, 4'hF, 3'b000);
    axi_write(7'h10, 32'hA, 4'hF, 3'b000);
    rd_check("ch1_restart", 7'h18, 32'd2);
    axi_write(7'h10, 32'hB, 4'hF, 3'b000);
    pulse_tick(3'b010, 3'b000);
    pulse_tick(3'b010, 3'b000);
    pulse_tick(3'b010, 3'b010);
    pulse_tick(3'b010, 3'b000);
    rd_check("ch1_en_cleared", 7'h10, 32'hA);
    rd_check("ch1_count_hold", 7'h18, 32'd0);
    rd_check("ch1_status", 7'h1C, 32'd1);
    check("ch1_irq_set", 32'(irq), 32'd1);
    axi_write(7'h1C, 32'd1, 4'b0010, 3'b000);
    rd_check("ch1_w1c_nostrb", 7'h1C, 32'd1);
    axi_write(7'h1C, 32'd1, 4'b0001, 3'b000);
    check("ch1_irq_lag", 32'(irq), 32'd1);
    wait_edge();
    check("ch1_irq_clear", 32'(irq), 32'd0);
    rd_check("ch1_status_clr", 7'h1C, 32'd0);

    // Ch2: width truncation, strobes, tick suppression in down mode
    axi_write(7'h24, 32'hAB, 4'h0, 3'b000);
    rd_check("ch2_load_nostrb", 7'h24, 32'd0);
    axi_write(7'h24, 32'h1FF, 4'hF, 3'b000);
    rd_check("ch2_load_trunc", 7'h24, 32'hFF);
    rd_check("ch2_count_up0", 7'h28, 32'd0);
    axi_write(7'h20, 32'h2, 4'hF, 3'b000);
    rd_check("ch2_dir_restart", 7'h28, 32'hFF);
    axi_write(7'h20, 32'h3, 4'hF, 3'b000);
    axi_write(7'h24, 32'h10, 4'hF, 3'b100);
    rd_check("ch2_load_tick", 7'h28, 32'h10);
    axi_write(7'h20, 32'h3, 4'hF, 3'b100);
    rd_check("ch2_ctrl_tick", 7'h28, 32'h10);
    pulse_tick(3'b100, 3'b000);
    rd_check("ch2_down_step", 7'h28, 32'h0F);
    axi_write(7'h28, 32'h55, 4'hF, 3'b000);
    rd_check("ch2_count_ro", 7'h28, 32'h0F);

    // Ch0: status clear racing a terminal tick, then LOAD write with tick
    axi_write(7'h0C, 32'd1, 4'h1, 3'b000);
    rd_check("ch0_status_clr", 7'h0C, 32'd0);
    pulse_tick(3'b001, 3'b000);
    axi_write(7'h0C, 32'd1, 4'h1, 3'b001);
    check("ch0_race_pulse", 32'(tc_pulse), 32'h1);
    rd_check("ch0_race_tc", 7'h0C, 32'd1);
    rd_check("ch0_race_count", 7'h08, 32'd0);
    pulse_tick(3'b001, 3'b000);
    pulse_tick(3'b001, 3'b000);
    axi_write(7'h04, 32'd5, 4'hF, 3'b001);
    rd_check("ch0_load_tick", 7'h08, 32'd0);
    rd_check("ch0_load5", 7'h04, 32'd5);

    // Out-of-range channel
    axi_write(7'h30, 32'hFFFF_FFFF, 4'hF, 3'b000);
    rd_check("oor_30", 7'h30, 32'd0);
    rd_check("oor_34", 7'h34, 32'd0);
    rd_check("oor_no_alias", 7'h00, 32'h5);

    // Write response backpressure
    wait_edge();
    awaddr = 7'h14; wdata = 32'd7; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    n = 0;
    while (awready !== 1'b1 && n < 20) begin
      wait_edge();
      n++;
    end
    check("bp_awready", 32'(awready), 32'd1);
    wait_edge();
    awaddr = 7'h34;
    for (int i = 0; i < 5; i++) begin
      check("bp_bvalid_hold", 32'(bvalid), 32'd1);
      check("bp_no_awready", 32'(awready), 32'd0);
      wait_edge();
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    wait_edge();
    check("bp_bvalid_drop", 32'(bvalid), 32'd0);
    rd_check("bp_load1", 7'h14, 32'd7);

    // Lone awvalid / lone wvalid are never accepted
    wait_edge();
    awaddr = 7'h04; wdata = 32'h99; awvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_edge();
      check("lone_aw", 32'(awready), 32'd0);
    end
    awvalid = 1'b0; wvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_edge();
      check("lone_w", 32'(wready), 32'd0);
    end
    wvalid = 1'b0;
    rd_check("lone_no_write", 7'h04, 32'd5);

    // Read data backpressure
    wait_edge();
    araddr = 7'h14; arvalid = 1'b1; rready = 1'b0;
    n = 0;
    while (arready !== 1'b1 && n < 20) begin
      wait_edge();
      n++;
    end
    check("rbp_arready", 32'(arready), 32'd1);
    wait_edge();
    arvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("rbp_rvalid", 32'(rvalid), 32'd1);
      check("rbp_rdata", rdata, 32'd7);
      wait_edge();
    end
    rready = 1'b1;
    wait_edge();
    check("rbp_rvalid_drop", 32'(rvalid), 32'd0);

    // Reset while bvalid is pending
    wait_edge();
    awaddr = 7'h04; wdata = 32'd9; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    n = 0;
    while (awready !== 1'b1 && n < 20) begin
      wait_edge();
      n++;
    end
    wait_edge();
    awvalid = 1'b0; wvalid = 1'b0;
    check("rst_mid_bvalid_pre", 32'(bvalid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_bvalid", 32'(bvalid), 32'd0);
    check("rst_mid_irq", 32'(irq), 32'd0);
    wait_edge();
    wait_edge();
    rst_n = 1'b1;
    rd_check("rst_mid_status0", 7'h0C, 32'd0);
    rd_check("rst_mid_load1", 7'h14, 32'd0);
    rd_check("rst_mid_ctrl0", 7'h00, 32'd0);
    axi_write(7'h04, 32'h42, 4'hF, 3'b000);
    rd_check("post_rst_write", 7'h04, 32'h42);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
